alu_ex: RTL and testbench



---
 rtl/alu_ex.sv | 145 ++++++++++++++
 tb/tb_alu_ex.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ex.sv
// alu_ex: execute-stage SIMD integer ALU with a registered 64-bit result.
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset, clears rDex
//   rAex           operand A, bit 0 is the MSB
//   rBex           operand B, also supplies per-lane shift amounts
//   functionCodeEX operation select
//   wwEX           lane width: 00=8, 01=16, 10=32, 11=64 bits
//   rDex           result, registered one cycle after the operands
// Optional feature: define ALU_SQRT_EN to build the per-lane VSQRT datapath;
// without it code 010010 returns 0 like any unlisted code.
module alu_ex (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [0:63] rAex,
    input  logic [0:63] rBex,
    input  logic [0:5]  functionCodeEX,
    input  logic [0:1]  wwEX,
    output logic [0:63] rDex
);
    localparam logic [5:0] VAND   = 6'h01;
    localparam logic [5:0] VOR    = 6'h02;
    localparam logic [5:0] VXOR   = 6'h03;
    localparam logic [5:0] VNOT   = 6'h04;
    localparam logic [5:0] VMOV   = 6'h05;
    localparam logic [5:0] VADD   = 6'h06;
    localparam logic [5:0] VSUB   = 6'h07;
    localparam logic [5:0] VMULEU = 6'h08;
    localparam logic [5:0] VMULOU = 6'h09;
    localparam logic [5:0] VSLL   = 6'h0A;
    localparam logic [5:0] VSRL   = 6'h0B;
    localparam logic [5:0] VSRA   = 6'h0C;
    localparam logic [5:0] VRTTH  = 6'h0D;
    localparam logic [5:0] VDIV   = 6'h0E;
    localparam logic [5:0] VMOD   = 6'h0F;
    localparam logic [5:0] VSQEU  = 6'h10;
    localparam logic [5:0] VSQOU  = 6'h11;
`ifdef ALU_SQRT_EN
    localparam logic [5:0] VSQRT  = 6'h12;
`endif

    // Internally everything is [63:0]; the value is identical, lane 0 sits at the top.
    logic [63:0] a, b, rd_d, rd_q, lane_res, wide_res;
    logic [5:0]  fn;
    logic [1:0]  ww;

    assign a    = rAex;
    assign b    = rBex;
    assign fn   = functionCodeEX;
    assign ww   = wwEX;
    assign rDex = rd_q;

`ifdef ALU_SQRT_EN
    // Digit-by-digit integer square root; the lane value arrives zero-extended.
    function automatic logic [63:0] isqrt(input logic [63:0] v);
        logic [63:0] x, r, one;
        x   = v;
        r   = '0;
        one = 64'h4000_0000_0000_0000;
        for (int i = 0; i < 32; i++) begin
            if (x >= r + one) begin
                x = x - (r + one);
                r = (r >> 1) + one;
            end else begin
                r = r >> 1;
            end
            one = one >> 2;
        end
        return r;
    endfunction
`endif

    // One lane of width w; operands arrive zero-extended to 64 bits and the
    // result is masked back to w bits.
    function automatic logic [63:0] lane_op(input logic [5:0] f, input logic [63:0] x,
                                            input logic [63:0] y, input int w);
        logic [63:0] m, sx, r;
        int sh;
        m  = w == 64 ? '1 : (64'd1 << w) - 64'd1;
        sh = int'(y[5:0]) & (w - 1);
        // Sign-extend the lane to 64 bits so a 64-bit arithmetic shift replicates its MSB.
        sx = x[w-1] ? x | ~m : x;
        case (f)
            VADD:    r = (x + y) & m;
            VSUB:    r = (x - y) & m;
            VSLL:    r = (x << sh) & m;
            VSRL:    r = x >> sh;
            VSRA:    r = 64'($signed(sx) >>> sh) & m;
            VRTTH:   r = ((x << (w / 2)) | (x >> (w / 2))) & m;
            VDIV:    r = y == '0 ? '0 : x / y;
            VMOD:    r = y == '0 ? x : x % y;
`ifdef ALU_SQRT_EN
            VSQRT:   r = isqrt(x);
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_w
        localparam int W = 8 << g;
        localparam int N = 64 / W;
        logic [63:0] lr, wr;
        always_comb begin
            lr = '0;
            for (int l = 0; l < N; l++)
                lr[63-l*W -: W] = W'(lane_op(fn, 64'(a[63-l*W -: W]), 64'(b[63-l*W -: W]), W));
        end
        if (W < 64) begin : g_mul
            logic [W-1:0] x, y;
            // Pair k takes lane 2k (even ops) or 2k+1 (odd ops); squares reuse A as the multiplier.
            always_comb begin
                wr = '0;
                x  = '0;
                y  = '0;
                for (int k = 0; k < N / 2; k++) begin
                    x = fn[0] ? a[63-(2*k+1)*W -: W] : a[63-2*k*W -: W];
                    y = fn[4] ? x : fn[0] ? b[63-(2*k+1)*W -: W] : b[63-2*k*W -: W];
                    wr[63-2*k*W -: 2*W] = (2*W)'(x) * (2*W)'(y);
                end
            end
        end else begin : g_nomul
            assign wr = '0;
        end
    end

    always_comb begin
        lane_res = ww == 2'd0 ? g_w[0].lr : ww == 2'd1 ? g_w[1].lr : ww == 2'd2 ? g_w[2].lr : g_w[3].lr;
        wide_res = ww == 2'd0 ? g_w[0].wr : ww == 2'd1 ? g_w[1].wr : ww == 2'd2 ? g_w[2].wr : g_w[3].wr;
        case (fn)
            VAND:                         rd_d = a & b;
            VOR:                          rd_d = a | b;
            VXOR:                         rd_d = a ^ b;
            VNOT:                         rd_d = ~a;
            VMOV:                         rd_d = a;
            VMULEU, VMULOU, VSQEU, VSQOU: rd_d = wide_res;
            default:                      rd_d = lane_res;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_q <= '0;
        else          rd_q <= rd_d;
    end
endmodule

// File: tb/tb_alu_ex.sv
// tb_alu_ex: scoreboard bench for alu_ex with directed and random operations against a lane model.
module tb_alu_ex;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] ra, rb, rd;
    logic [5:0]  fn;
    logic [1:0]  ww;
    int          total = 0;
    int          bad = 0;

`ifdef ALU_SQRT_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    typedef struct {
        logic [63:0] exp;
        string       nm;
    } item_t;
    item_t sb[$];
    item_t cur;

    alu_ex dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rAex           (ra),
        .rBex           (rb),
        .functionCodeEX (fn),
        .wwEX           (ww),
        .rDex           (rd)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] tsqrt(input logic [63:0] v);
        logic [63:0] lo, hi, mid;
        lo = 0;
        hi = 64'hFFFF_FFFF;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic logic [63:0] model(input logic [5:0] f, input logic [1:0] wsel,
                                          input logic [63:0] a, input logic [63:0] b);
        int w, n, s;
        logic [63:0] m, r, x, y, v;
        logic [63:0] la[8];
        logic [63:0] lb[8];
        bit odd, sq;
        w = 8 << wsel;
        n = 64 / w;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r = 0;
        for (int i = 0; i < n; i++) begin
            la[i] = (a >> (64 - (i + 1) * w)) & m;
            lb[i] = (b >> (64 - (i + 1) * w)) & m;
        end
        case (f)
            6'h01: return a & b;
            6'h02: return a | b;
            6'h03: return a ^ b;
            6'h04: return ~a;
            6'h05: return a;
            6'h08, 6'h09, 6'h10, 6'h11: begin
                if (w == 64) return 0;
                odd = (f == 6'h09) || (f == 6'h11);
                sq  = (f == 6'h10) || (f == 6'h11);
                for (int k = 0; k < n / 2; k++) begin
                    x = odd ? la[2*k+1] : la[2*k];
                    y = sq ? x : (odd ? lb[2*k+1] : lb[2*k]);
                    r |= (x * y) << (64 - (k + 1) * 2 * w);
                end
                return r;
            end
            default: begin
                for (int i = 0; i < n; i++) begin
                    s = int'(lb[i] % 64'(w));
                    case (f)
                        6'h06: v = la[i] + lb[i];
                        6'h07: v = la[i] - lb[i];
                        6'h0A: v = la[i] << s;
                        6'h0B: v = la[i] >> s;
                        6'h0C: begin
                            v = la[i] >> s;
                            if (la[i][w-1]) v |= m & ~(m >> s);
                        end
                        6'h0D: v = (la[i] << (w / 2)) | (la[i] >> (w / 2));
                        6'h0E: v = lb[i] == 0 ? 0 : la[i] / lb[i];
                        6'h0F: v = lb[i] == 0 ? la[i] : la[i] % lb[i];
                        6'h12: v = SQ ? tsqrt(la[i]) : 0;
                        default: return 0;
                    endcase
                    r |= (v & m) << (64 - (i + 1) * w);
                end
                return r;
            end
        endcase
    endfunction

    task automatic issue(input logic [5:0] f, input logic [1:0] w, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] e, input string nm);
        item_t it;
        @(negedge clk);
        fn = f;
        ww = w;
        ra = x;
        rb = y;
        it.exp = e;
        it.nm  = nm;
        sb.push_back(it);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d pending exp=0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: a result is due one edge after each issue.
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            check(cur.nm, rd, cur.exp);
        end
    end

    localparam logic [63:0] ONES = '1;
    localparam logic [63:0] KA   = 64'h0123_4567_89AB_CDEF;
    int codes[18] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18};

    initial begin
        logic [5:0]  f;
        logic [1:0]  w;
        logic [63:0] x, y, zm;
        reset_n = 1'b0;
        fn = 0;
        ww = 0;
        ra = 0;
        rb = 0;
        #2 check("reset_init", rd, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        issue(6'h06, 2'd0, ONES, ONES, 64'hFEFE_FEFE_FEFE_FEFE, "vadd_b");
        issue(6'h06, 2'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, "vadd_d");
        issue(6'h07, 2'd1, ONES, ONES, 64'h0, "vsub_h");
        issue(6'h07, 2'd3, ONES, ONES, 64'h0, "vsub_d");
        issue(6'h01, 2'd2, ONES, ONES, ONES, "vand");
        issue(6'h04, 2'd0, ONES, ONES, 64'h0, "vnot");
        issue(6'h08, 2'd0, ONES, ONES, 64'hFE01_FE01_FE01_FE01, "vmuleu_b");
        issue(6'h09, 2'd1, ONES, ONES, 64'hFFFE_0001_FFFE_0001, "vmulou_h");
        issue(6'h10, 2'd2, ONES, ONES, 64'hFFFF_FFFE_0000_0001, "vsqeu_w");
        issue(6'h08, 2'd3, ONES, ONES, 64'h0, "vmuleu_d");
        issue(6'h0A, 2'd1, ONES, ONES, 64'h8000_8000_8000_8000, "vsll_h");
        issue(6'h0B, 2'd1, ONES, ONES, 64'h0001_0001_0001_0001, "vsrl_h");
        issue(6'h0C, 2'd1, ONES, ONES, ONES, "vsra_h");
        issue(6'h0D, 2'd0, ONES, ONES, ONES, "vrtth_b");
        issue(6'h0D, 2'd1, 64'h1234_5678_9ABC_DEF0, 0, 64'h3412_7856_BC9A_F0DE, "vrtth_h");
        issue(6'h0E, 2'd2, ONES, ONES, 64'h0000_0001_0000_0001, "vdiv_w");
        issue(6'h0F, 2'd0, ONES, ONES, 64'h0, "vmod_b");
        issue(6'h0E, 2'd0, KA, 64'h0, 64'h0, "vdiv_zero");
        issue(6'h0F, 2'd0, KA, 64'h0, KA, "vmod_zero");
        issue(6'h12, 2'd0, ONES, 0, SQ ? 64'h0F0F_0F0F_0F0F_0F0F : 64'h0, "vsqrt_b");
        issue(6'h12, 2'd1, ONES, 0, SQ ? 64'h00FF_00FF_00FF_00FF : 64'h0, "vsqrt_h");
        issue(6'h12, 2'd3, ONES, 0, SQ ? 64'h0000_0000_FFFF_FFFF : 64'h0, "vsqrt_d");
        issue(6'h3F, 2'd0, ONES, ONES, 64'h0, "unlisted_3f");
        issue(6'h00, 2'd2, ONES, ONES, 64'h0, "unlisted_00");
        for (int i = 0; i < 400; i++) begin
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'(codes[$urandom_range(0, 17)]);
            w = 2'($urandom_range(0, 3));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            zm = 0;
            for (int j = 0; j < 8; j++) zm[j*8 +: 8] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
            case ($urandom_range(0, 4))
                0: x = ONES;
                1: y = y & zm;
                2: y = y >> $urandom_range(0, 63);
                default: ;
            endcase
            issue(f, w, x, y, model(f, w, x, y), $sformatf("rnd%0d_f%02h_w%0d", i, f, w));
        end
        issue(6'h05, 2'd0, KA, 0, KA, "vmov_pre_reset");
        drain();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check("reset_async", rd, 64'h0);
        @(posedge clk);
        #1 check("reset_hold", rd, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("reset_release", rd, 64'h0);
        issue(6'h06, 2'd0, KA, KA, model(6'h06, 2'd0, KA, KA), "post_reset_vadd");
        issue(6'h03, 2'd1, KA, ONES, ~KA, "post_reset_vxor");
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
